// File: rtl/v_lsu_pkg.sv
// Shared CPU definitions used by the MEM-stage load/store unit.
// Opcodes, LSU state encoding and default bus widths.
package v_cpu_pkg;

  localparam logic [5:0] OP_SW = 6'b010000;
  localparam logic [5:0] OP_LW = 6'b010001;

  localparam int LSU_ADDR_W = 8;
  localparam int LSU_DATA_W = 32;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/v_lsu_if.sv
// Word bus between the LSU and data memory.
// req/gnt request phase, rvalid response phase.
interface v_lsu_if
  import v_cpu_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = LSU_DATA_W
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/v_lsu_timer.sv
// Access watchdog for the LSU (built only with LSU_TIMEOUT_EN).
// Clears on load, counts while enabled, flags the final cycle.
module v_lsu_timer #(
  parameter int CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(CYC + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire = en && (cnt_q == W'(CYC - 1));

endmodule

// File: rtl/v_lsu.sv
// MEM-stage load/store initiator driving the req/gnt/rvalid bus.
// Define LSU_TIMEOUT_EN to abort accesses that stall too long.
module v_lsu
  import v_cpu_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = LSU_DATA_W
`ifdef LSU_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [5:0]        op_i,
  input  logic [31:0]       addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  v_lsu_if.master           mem
);

  lsu_state_t state_q, state_d;

  logic              accept;
  logic              capture;
  logic              abort;
  logic              expire;
  logic              is_mem;
  logic              range_bad;
  logic              we_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  assign is_mem    = (op_i == OP_SW) || (op_i == OP_LW);
  assign range_bad = |addr_i[31:ADDR_W];

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= LSU_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      LSU_IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          state_d = (is_mem && !range_bad) ? LSU_REQ : LSU_DONE;
        end
      end
      LSU_REQ: begin
        if (mem.gnt) begin
          state_d = we_q ? LSU_DONE : LSU_RESP;
        end else if (expire) begin
          abort   = 1'b1;
          state_d = LSU_DONE;
        end
      end
      LSU_RESP: begin
        if (mem.rvalid) begin
          capture = 1'b1;
          state_d = LSU_DONE;
        end else if (expire) begin
          abort   = 1'b1;
          state_d = LSU_DONE;
        end
      end
      LSU_DONE: state_d = LSU_IDLE;
    endcase
  end

  // Non-memory ops leave rdata untouched; errors force it to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= (op_i == OP_SW);
        err_q   <= is_mem && range_bad;
        addr_q  <= addr_i[ADDR_W-1:0];
        wdata_q <= wdata_i;
        if (is_mem && range_bad) rdata_q <= '0;
      end
      if (capture) rdata_q <= mem.rdata;
      if (abort) begin
        err_q   <= 1'b1;
        rdata_q <= '0;
      end
    end
  end

`ifdef LSU_TIMEOUT_EN
  logic tmr_load;
  logic tmr_en;

  assign tmr_load = (state_q == LSU_IDLE);
  assign tmr_en   = (state_q == LSU_REQ) || (state_q == LSU_RESP);

  v_lsu_timer #(
    .CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .en     (tmr_en),
    .expire (expire)
  );
`else
  assign expire = 1'b0;
`endif

  assign busy_o    = (state_q != LSU_IDLE);
  assign done_o    = (state_q == LSU_DONE);
  assign err_o     = done_o && err_q;
  assign rdata_o   = rdata_q;

  assign mem.req   = (state_q == LSU_REQ);
  assign mem.we    = mem.req && we_q;
  assign mem.addr  = mem.req ? addr_q : '0;
  assign mem.wdata = mem.req ? wdata_q : '0;

endmodule

// File: tb/tb_v_lsu.sv
// Directed bench for v_lsu: store, load, pass-through, range error,
// reset abort and (with LSU_TIMEOUT_EN) the bus watchdog.
module tb_v_lsu;
  import v_cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [5:0]  op_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        err_o;

  int n_cmp;
  int n_bad;
  int reqs;
  bit seen;

  v_lsu_if #(.ADDR_W(8), .DATA_W(32)) mem_bus ();

  v_lsu #(
    .ADDR_W (8),
    .DATA_W (32)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .op_i    (op_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .rdata_o (rdata_o),
    .err_o   (err_o),
    .mem     (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start_i = 1'b0;
    op_i = 6'd0;
    addr_i = 32'd0;
    wdata_i = 32'd0;
    mem_bus.gnt = 1'b0;
    mem_bus.rvalid = 1'b0;
    mem_bus.rdata = 32'd0;
    step();
    step();
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_req", mem_bus.req, 0);
    chk("rst_addr", mem_bus.addr, 0);
    rst_n = 1'b1;
    step();

    // SW addr 5, gnt tied high
    start_i = 1'b1;
    op_i = OP_SW;
    addr_i = 32'd5;
    wdata_i = 32'hDEAD_BEEF;
    mem_bus.gnt = 1'b1;
    step();
    start_i = 1'b0;
    chk("sw_req", mem_bus.req, 1);
    chk("sw_we", mem_bus.we, 1);
    chk("sw_addr", mem_bus.addr, 32'h05);
    chk("sw_wdata", mem_bus.wdata, 32'hDEAD_BEEF);
    chk("sw_busy", busy_o, 1);
    chk("sw_nodone", done_o, 0);
    step();
    chk("sw_done", done_o, 1);
    chk("sw_err", err_o, 0);
    chk("sw_busy_done", busy_o, 1);
    chk("sw_req_off", mem_bus.req, 0);
    chk("sw_wdata_off", mem_bus.wdata, 0);
    start_i = 1'b1;
    op_i = OP_LW;
    step();
    start_i = 1'b0;
    mem_bus.gnt = 1'b0;
    chk("sw_idle_busy", busy_o, 0);
    chk("done_start_ign", mem_bus.req, 0);
    step();
    chk("done_start_ign2", busy_o, 0);

    // LW addr 5: three cycles without gnt, rvalid two cycles after gnt
    start_i = 1'b1;
    op_i = OP_LW;
    addr_i = 32'd5;
    step();
    start_i = 1'b0;
    mem_bus.rvalid = 1'b1;
    mem_bus.rdata = 32'hFFFF_0000;
    chk("lw_req1", mem_bus.req, 1);
    chk("lw_we", mem_bus.we, 0);
    chk("lw_addr", mem_bus.addr, 32'h05);
    step();
    mem_bus.rvalid = 1'b0;
    chk("lw_rv_in_req", mem_bus.req, 1);
    chk("lw_rv_rdata", rdata_o, 0);
    step();
    chk("lw_req3", mem_bus.req, 1);
    step();
    mem_bus.gnt = 1'b1;
    chk("lw_req4", mem_bus.req, 1);
    step();
    mem_bus.gnt = 1'b0;
    chk("lw_resp_req", mem_bus.req, 0);
    chk("lw_resp_addr", mem_bus.addr, 0);
    chk("lw_resp_busy", busy_o, 1);
    step();
    chk("lw_resp_wait", done_o, 0);
    mem_bus.rvalid = 1'b1;
    mem_bus.rdata = 32'h1234_5678;
    step();
    mem_bus.rvalid = 1'b0;
    mem_bus.rdata = 32'h0;
    chk("lw_done", done_o, 1);
    chk("lw_rdata", rdata_o, 32'h1234_5678);
    chk("lw_err", err_o, 0);
    step();
    chk("lw_idle", busy_o, 0);
    chk("lw_hold", rdata_o, 32'h1234_5678);

    // Non-memory op passes through
    start_i = 1'b1;
    op_i = 6'b000010;
    addr_i = 32'd9;
    step();
    start_i = 1'b0;
    chk("nm_done", done_o, 1);
    chk("nm_req", mem_bus.req, 0);
    chk("nm_err", err_o, 0);
    chk("nm_rdata", rdata_o, 32'h1234_5678);
    step();
    chk("nm_idle", busy_o, 0);
    chk("nm_req2", mem_bus.req, 0);

    // Reset while waiting in RESP, then a late rvalid
    start_i = 1'b1;
    op_i = OP_LW;
    addr_i = 32'd7;
    mem_bus.gnt = 1'b1;
    step();
    start_i = 1'b0;
    step();
    mem_bus.gnt = 1'b0;
    chk("rr_resp_busy", busy_o, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    mem_bus.rvalid = 1'b1;
    mem_bus.rdata = 32'hAAAA_5555;
    chk("rr_busy", busy_o, 0);
    chk("rr_done", done_o, 0);
    chk("rr_rdata", rdata_o, 0);
    step();
    mem_bus.rvalid = 1'b0;
    chk("rr_late_done", done_o, 0);
    chk("rr_late_busy", busy_o, 0);
    chk("rr_late_rdata", rdata_o, 0);

    // LW at top word address, rvalid on the first usable cycle
    start_i = 1'b1;
    op_i = OP_LW;
    addr_i = 32'h0000_00FF;
    mem_bus.gnt = 1'b1;
    step();
    start_i = 1'b0;
    chk("top_addr", mem_bus.addr, 32'hFF);
    step();
    mem_bus.gnt = 1'b0;
    mem_bus.rvalid = 1'b1;
    mem_bus.rdata = 32'hCAFE_F00D;
    step();
    mem_bus.rvalid = 1'b0;
    chk("top_done", done_o, 1);
    chk("top_rdata", rdata_o, 32'hCAFE_F00D);
    step();

    // Address just past the bus range
    start_i = 1'b1;
    op_i = OP_LW;
    addr_i = 32'h0000_0100;
    step();
    start_i = 1'b0;
    chk("rng_done", done_o, 1);
    chk("rng_err", err_o, 1);
    chk("rng_rdata", rdata_o, 0);
    chk("rng_req", mem_bus.req, 0);
    step();
    chk("rng_idle", busy_o, 0);
    chk("rng_err_off", err_o, 0);

    // Bus never grants
    start_i = 1'b1;
    op_i = OP_SW;
    addr_i = 32'd1;
    wdata_i = 32'h0000_0042;
    step();
    start_i = 1'b0;
`ifdef LSU_TIMEOUT_EN
    reqs = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (mem_bus.req) reqs++;
      if (done_o) begin
        seen = 1'b1;
        chk("tmo_err", err_o, 1);
        chk("tmo_rdata", rdata_o, 0);
      end
      step();
    end
    chk("tmo_seen", 32'(seen), 1);
    chk("tmo_reqs", reqs, 16);
    chk("tmo_idle", busy_o, 0);
`else
    reqs = 0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (mem_bus.req) reqs++;
      if (done_o) seen = 1'b1;
      step();
    end
    chk("hang_busy", busy_o, 1);
    chk("hang_reqs", reqs, 30);
    chk("hang_nodone", 32'(seen), 0);
    mem_bus.gnt = 1'b1;
    step();
    mem_bus.gnt = 1'b0;
    chk("hang_done", done_o, 1);
    chk("hang_err", err_o, 0);
    step();
    chk("hang_idle", busy_o, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
